// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI command path.
// Holds the scheduler state encoding, the frame start bits and the timeout response pattern.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } sd_state_t;

    localparam logic [1:0]  FRAME_START  = 2'b01;
    localparam logic [39:0] RESP_TIMEOUT = 40'hFF_FFFF_FFFF;
    localparam int          CRC_BITS     = 40;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, zero seed), one message bit per cycle, MSB first.
// Latency: crc reflects a bit the cycle after bit_valid; always accepts input.
module sd_crc7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;
    assign fb = crc[6] ^ bit_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (bit_valid) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    end

endmodule

// File: rtl/sd_spi_cmd_scheduler.sv
// Round-robin arbiter that frames SD commands (CRC7), runs one engine transaction, then idles sd_cs.
// Latency: eng_start 42 cycles after req_ready; req_done 1 cycle after eng_done; no grant until GAP ends.
module sd_spi_cmd_scheduler
    import sd_pkg::*;
#(
    parameter int GAP_CYCLES      = 64,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0][5:0] req_index,
    input  logic [1:0][31:0] req_arg,
    input  logic [1:0][2:0] req_resp_len,
    output logic [1:0]      req_done,
    output logic [39:0]     resp,
    output logic            resp_timeout,
    output logic            eng_start,
    output logic [47:0]     eng_cmd,
    output logic [2:0]      eng_resp_len,
    input  logic            eng_done,
    input  logic [39:0]     eng_resp,
    input  logic            eng_timeout,
    output logic            sd_cs,
    output logic            fast_clk
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);

    sd_state_t         state;
    logic              owner;
    logic              last_grant;
    logic              winner;
    logic [5:0]        cap_index;
    logic [31:0]       cap_arg;
    logic [2:0]        cap_len;
    logic [39:0]       frame_sh;
    logic [5:0]        crc_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              crc_clear;
    logic              crc_bit_vld;
    logic [6:0]        crc;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        winner = req_valid[1];
        if (req_valid == 2'b11) begin
            winner = ~last_grant;
        end
    end

    // CRC phase: count 0 clears, counts 1..40 feed bits, count 41 latches the frame.
    assign crc_clear   = (state == ST_CRC) && (crc_cnt == 6'd0);
    assign crc_bit_vld = (state == ST_CRC) && (crc_cnt != 6'd0) && (crc_cnt <= 6'(CRC_BITS));

    sd_crc7 u_crc7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (crc_clear),
        .bit_valid (crc_bit_vld),
        .bit_in    (frame_sh[39]),
        .crc       (crc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            cap_index    <= '0;
            cap_arg      <= '0;
            cap_len      <= '0;
            frame_sh     <= '0;
            crc_cnt      <= '0;
            gap_cnt      <= '0;
            wd_cnt       <= '0;
            req_ready    <= '0;
            req_done     <= '0;
            resp         <= '0;
            resp_timeout <= 1'b0;
            eng_start    <= 1'b0;
            eng_cmd      <= '0;
            eng_resp_len <= '0;
            sd_cs        <= 1'b1;
            fast_clk     <= 1'b0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            eng_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_ready  <= winner ? 2'b10 : 2'b01;
                        owner      <= winner;
                        last_grant <= winner;
                        cap_index  <= req_index[winner];
                        cap_arg    <= req_arg[winner];
                        cap_len    <= req_resp_len[winner];
                        frame_sh   <= {FRAME_START, req_index[winner], req_arg[winner]};
                        crc_cnt    <= '0;
                        state      <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    crc_cnt <= crc_cnt + 6'd1;
                    if (crc_bit_vld) begin
                        frame_sh <= {frame_sh[38:0], 1'b0};
                    end
                    if (crc_cnt == 6'(CRC_BITS + 1)) begin
                        eng_cmd      <= {FRAME_START, cap_index, cap_arg, crc, 1'b1};
                        eng_resp_len <= cap_len;
                        eng_start    <= 1'b1;
                        sd_cs        <= 1'b0;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        resp         <= eng_resp;
                        resp_timeout <= eng_timeout;
                        req_done     <= owner ? 2'b10 : 2'b01;
                        if (cap_index == 6'd41 && !eng_timeout && eng_resp[39:32] == 8'h00) begin
                            fast_clk <= 1'b1;
                        end
                        sd_cs   <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) begin
                        resp         <= RESP_TIMEOUT;
                        resp_timeout <= 1'b1;
                        req_done     <= owner ? 2'b10 : 2'b01;
                        sd_cs        <= 1'b1;
                        gap_cnt      <= '0;
                        state        <= ST_GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_scheduler.sv
// Randomized bench for sd_spi_cmd_scheduler against a transaction-level reference model.
module tb_sd_spi_cmd_scheduler;

    localparam int G  = 8;
    localparam int WD = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][5:0]  req_index;
    logic [1:0][31:0] req_arg;
    logic [1:0][2:0]  req_resp_len;
    logic [1:0]       req_done;
    logic [39:0]      resp;
    logic             resp_timeout;
    logic             eng_start;
    logic [47:0]      eng_cmd;
    logic [2:0]       eng_resp_len;
    logic             eng_done;
    logic [39:0]      eng_resp;
    logic             eng_timeout;
    logic             sd_cs;
    logic             fast_clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic        m_last;
    logic        m_fast;
    logic [47:0] last_cmd;

    always #5 clk = ~clk;

    sd_spi_cmd_scheduler #(.GAP_CYCLES(G), .WATCHDOG_CYCLES(WD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .req_arg      (req_arg),
        .req_resp_len (req_resp_len),
        .req_done     (req_done),
        .resp         (resp),
        .resp_timeout (resp_timeout),
        .eng_start    (eng_start),
        .eng_cmd      (eng_cmd),
        .eng_resp_len (eng_resp_len),
        .eng_done     (eng_done),
        .eng_resp     (eng_resp),
        .eng_timeout  (eng_timeout),
        .sd_cs        (sd_cs),
        .fast_clk     (fast_clk)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of (message * x^7) divided by 0x89.
    function automatic logic [6:0] crc7_ref(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    task automatic set_req(input int r, input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] len);
        req_valid[r]    = 1'b1;
        req_index[r]    = idx;
        req_arg[r]      = arg;
        req_resp_len[r] = len;
    endtask

    // One full command: grant, framing, engine wait, completion. Entered and left on a negedge.
    task automatic run_txn(input int exp_gap, input int dly, input logic no_done,
                           input logic [39:0] er, input logic eto);
        int          n;
        int          k;
        logic        w;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [2:0]  len;
        logic [47:0] exp_cmd;
        logic [47:0] cmd0;
        logic        bad_idle;
        logic        bad_crc;
        logic        bad_wait;
        bad_idle = 1'b0;
        bad_crc  = 1'b0;
        bad_wait = 1'b0;
        n = 0;
        while (req_ready == 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
            eng_done = 1'($urandom_range(0, 1));
            eng_resp = {$urandom, 8'($urandom)};
            if (sd_cs !== 1'b1 || req_done !== 2'b00) bad_idle = 1'b1;
        end
        if (exp_gap >= 0) check("grant_gap", 64'(n), 64'(exp_gap));
        w = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        check("grant", 64'(req_ready), w ? 64'd2 : 64'd1);
        check("idle_quiet", 64'(bad_idle), 64'd0);
        m_last = w;
        idx = req_index[w];
        arg = req_arg[w];
        len = req_resp_len[w];
        req_valid[w] = 1'b0;
        exp_cmd = {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};

        n = 0;
        while (eng_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            eng_done = 1'($urandom_range(0, 1));
            if (eng_start !== 1'b1 && (sd_cs !== 1'b1 || req_done !== 2'b00 || req_ready !== 2'b00))
                bad_crc = 1'b1;
        end
        check("start_lat", 64'(n), 64'd42);
        check("crc_quiet", 64'(bad_crc), 64'd0);
        check("eng_cmd", 64'(eng_cmd), 64'(exp_cmd));
        check("eng_resp_len", 64'(eng_resp_len), 64'(len));
        check("issue_cs", 64'(sd_cs), 64'd0);
        cmd0     = eng_cmd;
        last_cmd = eng_cmd;

        // A pulse during the ISSUE cycle must be ignored.
        eng_resp    = er;
        eng_timeout = eto;
        eng_done    = 1'($urandom_range(0, 1));
        k = 0;
        do begin
            @(negedge clk);
            k++;
            eng_done = (!no_done && k == dly);
            if (req_done === 2'b00 && (sd_cs !== 1'b0 || eng_cmd !== cmd0)) bad_wait = 1'b1;
        end while (req_done === 2'b00 && k < WD + 10);
        eng_done    = 1'b0;
        eng_resp    = {$urandom, 8'($urandom)};
        eng_timeout = 1'($urandom_range(0, 1));

        check("done_lat", 64'(k), no_done ? 64'(WD + 1) : 64'(dly + 1));
        check("wait_hold", 64'(bad_wait), 64'd0);
        check("req_done", 64'(req_done), w ? 64'd2 : 64'd1);
        check("resp", 64'(resp), no_done ? 64'hFF_FFFF_FFFF : 64'(er));
        check("resp_timeout", 64'(resp_timeout), no_done ? 64'd1 : 64'(eto));
        check("gap_cs", 64'(sd_cs), 64'd1);
        if (!no_done && idx == 6'd41 && !eto && er[39:32] == 8'h00) m_fast = 1'b1;
        check("fast_clk", 64'(fast_clk), 64'(m_fast));
    endtask

    initial begin
        int n;
        logic [39:0] er;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_index    = '0;
        req_arg      = '0;
        req_resp_len = '0;
        eng_done     = 1'b0;
        eng_resp     = '0;
        eng_timeout  = 1'b0;
        m_last       = 1'b1;
        m_fast       = 1'b0;
        last_cmd     = '0;
        repeat (3) @(negedge clk);

        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_resp", 64'(resp), 64'd0);
        check("rst_timeout", 64'(resp_timeout), 64'd0);
        check("rst_start", 64'(eng_start), 64'd0);
        check("rst_cmd", 64'(eng_cmd), 64'd0);
        check("rst_len", 64'(eng_resp_len), 64'd0);
        check("rst_cs", 64'(sd_cs), 64'd1);
        check("rst_fast", 64'(fast_clk), 64'd0);
        rst_n = 1'b1;

        set_req(0, 6'd0, 32'h0, 3'd1);
        run_txn(-1, 5, 1'b0, 40'h01_0000_0000, 1'b0);
        check("cmd0_frame", 64'(last_cmd), 64'h40_0000_0000_95);

        set_req(0, 6'd8, 32'h1AA, 3'd5);
        run_txn(G + 1, 3, 1'b0, 40'h01_0000_01AA, 1'b0);
        check("cmd8_frame", 64'(last_cmd), 64'h48_0000_01AA_87);

        set_req(1, 6'd41, 32'h4000_0000, 3'd1);
        run_txn(G + 1, 20, 1'b0, 40'h00_1234_5678, 1'b0);
        check("acmd41_frame", 64'(last_cmd), 64'h69_4000_0000_77);

        // Watchdog expiry, then eng_done coinciding with the expiry cycle.
        set_req(0, 6'd17, $urandom, 3'd1);
        run_txn(G + 1, 1, 1'b1, 40'h0, 1'b0);
        set_req(1, 6'd13, $urandom, 3'd2);
        run_txn(G + 1, WD, 1'b0, {$urandom, 8'($urandom)}, 1'b1);

        for (int t = 0; t < 16; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && $urandom_range(0, 1) == 1)
                    set_req(r, ($urandom_range(0, 3) == 0) ? 6'd41 : 6'($urandom), $urandom,
                            3'($urandom_range(1, 5)));
            end
            if (req_valid == 2'b00)
                set_req(int'($urandom_range(0, 1)), 6'($urandom), $urandom, 3'($urandom_range(1, 5)));
            er = {($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom), $urandom};
            run_txn(G + 1, int'($urandom_range(1, WD)), ($urandom_range(0, 7) == 0), er,
                    1'($urandom_range(0, 1)));
        end

        // Reset while waiting on the engine; a late eng_done must not complete anything.
        if (req_valid == 2'b00) set_req(0, 6'd55, $urandom, 3'd3);
        n = 0;
        while (eng_start !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("pre_rst_cs", 64'(sd_cs), 64'd0);
        rst_n = 1'b0;
        set_req(0, 6'd2, $urandom, 3'd5);
        set_req(1, 6'd9, $urandom, 3'd5);
        m_last = 1'b1;
        m_fast = 1'b0;
        @(negedge clk);
        check("abort_cs", 64'(sd_cs), 64'd1);
        check("abort_done", 64'(req_done), 64'd0);
        check("abort_fast", 64'(fast_clk), 64'd0);
        eng_done = 1'b1;
        eng_resp = 40'h00_0000_0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        check("late_done", 64'(req_done), 64'd0);

        run_txn(-1, 7, 1'b0, {$urandom, 8'($urandom)}, 1'b0);
        run_txn(G + 1, 4, 1'b0, {$urandom, 8'($urandom)}, 1'b0);
        set_req(0, 6'd1, $urandom, 3'd1);
        set_req(1, 6'd24, $urandom, 3'd1);
        run_txn(G + 1, 2, 1'b0, {$urandom, 8'($urandom)}, 1'b0);
        run_txn(G + 1, 9, 1'b0, {$urandom, 8'($urandom)}, 1'b0);
        check("final_fast", 64'(fast_clk), 64'(m_fast));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
